pc_ctrl: RTL

Sequencer for the fetch-stage next-PC datapath of the pipelined RV32 core. It owns the architectural PC register and drives the NPC unit's operation select and write enable. It arbitrates between sequential fetch, EX-stage redirects (branch, JAL, JALR), load-use stalls and instruction-memory wait states, and issues the matching pipeline flush/bubble controls.

---
 rtl/pc_ctrl_pkg.sv | 26 ++
 rtl/pc_ctrl_satcnt.sv | 24 ++
 rtl/pc_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared NPC op codes and pc_ctrl state encodings
package pc_ctrl_pkg;

   typedef enum logic [2:0] {
      NPC_PLUS4  = 3'b000,
      NPC_BRANCH = 3'b001,
      NPC_JUMP   = 3'b010,
      NPC_JALR   = 3'b100
   } npc_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_PEND = 2'd3
   } pc_state_e;

   // JALR beats JAL beats a taken branch; nothing active selects PC+4.
   function automatic npc_op_e redirect_op(input logic jalr, input logic jal, input logic br);
      if (jalr)     return NPC_JALR;
      else if (jal) return NPC_JUMP;
      else if (br)  return NPC_BRANCH;
      else          return NPC_PLUS4;
   endfunction

endpackage

// File: rtl/pc_ctrl_satcnt.sv
// rtl/pc_ctrl_satcnt.sv - 32-bit saturating event counter with synchronous clear
module pc_ctrl_satcnt (
   input  logic        clk,
   input  logic        clr_i,
   input  logic        inc_i,
   output logic [31:0] cnt_o
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (clr_i) cnt_q <= 32'd0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch-stage PC sequencer: redirects, load-use stalls, imem wait states
// Optional perf counters enabled by defining PC_CTRL_PERF_EN.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc,
   input  logic        ex_br_taken,
   input  logic        ex_jal,
   input  logic        ex_jalr,
   input  logic        ld_use_stall,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   output logic [2:0]  npc_op,
   output logic        pc_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic [31:0] redirect_cnt,
   output logic [31:0] stall_cnt
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic        redir;
   npc_op_e     win_op;

   assign redir  = ex_jalr | ex_jal | ex_br_taken;
   assign win_op = redirect_op(ex_jalr, ex_jal, ex_br_taken);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      imem_req      = 1'b0;
      npc_op        = NPC_PLUS4;
      pc_write      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      if (!rst) begin
         unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN, S_WAIT: begin
               imem_req = 1'b1;
               npc_op   = win_op;
               if (redir) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  if (imem_ready) begin
                     pc_write = 1'b1;
                     pc_d     = npc;
                     state_d  = S_RUN;
                  end else begin
                     pend_target_d = npc;
                     state_d       = S_PEND;
                  end
               end else if (imem_ready && !ld_use_stall) begin
                  pc_write = 1'b1;
                  pc_d     = npc;
                  state_d  = S_RUN;
               end else begin
                  id_ex_flush = ld_use_stall;
                  state_d     = imem_ready ? S_RUN : S_WAIT;
               end
            end
            S_PEND: begin
               imem_req = 1'b1;
               if (redir) begin
                  // Newest redirect replaces the pending target.
                  npc_op      = win_op;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  if (imem_ready) begin
                     pc_write = 1'b1;
                     pc_d     = npc;
                     state_d  = S_RUN;
                  end else begin
                     pend_target_d = npc;
                  end
               end else begin
                  id_ex_flush = ld_use_stall;
                  if (imem_ready) begin
                     // The returned word belongs to the stale PC; drop it.
                     pc_d        = pend_target_q;
                     if_id_flush = 1'b1;
                     state_d     = S_RUN;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         pend_target_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;

`ifdef PC_CTRL_PERF_EN
   logic redirect_acc;
   logic stall_inc;

   assign redirect_acc = imem_req & redir;
   assign stall_inc    = imem_req & ~pc_write &
                         ~((state_q == S_PEND) & ~redir & imem_ready);

   pc_ctrl_satcnt u_redirect_cnt (
      .clk   (clk),
      .clr_i (rst),
      .inc_i (redirect_acc),
      .cnt_o (redirect_cnt)
   );

   pc_ctrl_satcnt u_stall_cnt (
      .clk   (clk),
      .clr_i (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );
`else
   assign redirect_cnt = 32'd0;
   assign stall_cnt    = 32'd0;
`endif

endmodule
